// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: owns the PC, issues in-order word fetches over a
// req/gnt + rvalid memory interface, buffers returned words with their PCs and
// hands them to decode via valid/ready. Redirects flush the buffer and drop any
// responses still in flight.
// Optional: define IFETCH_BYPASS_EN to forward a response straight to decode
// when the buffer is empty (one cycle less latency).
module ifetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [OW-1:0]   outstanding, drop, out_next;
  logic [TW-1:0]   tag_wr, tag_rd;
  logic [31:0]     tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     fifo_data [FIFO_DEPTH];
  logic [31:0]     fifo_addr [FIFO_DEPTH];

  logic        fire, rv, keep, byp, buf_valid, push, pop;
  logic [31:0] tag_head, target;
  logic        unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr_i[1:0];
  assign target          = {jump_addr_i[31:2], 2'b00};

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Only issue when the response is guaranteed a buffer slot (dropped ones excluded).
  assign mem_req_o  = (state == S_RUN) &&
                      (32'(outstanding) < MAX_OUTSTANDING) &&
                      (32'(count) + 32'(outstanding) - 32'(drop) < FIFO_DEPTH);
  assign mem_addr_o = pc;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign fire      = mem_req_o & mem_gnt_i;
  assign rv        = mem_rvalid_i & (outstanding != '0);
  assign tag_head  = tag_mem[tag_rd];
  assign keep      = rv & (drop == '0) & ~jump_en_i;
  assign buf_valid = (count != '0);
  assign out_next  = outstanding + OW'(fire) - OW'(rv);

`ifdef IFETCH_BYPASS_EN
  assign byp = keep & ~buf_valid;
`else
  assign byp = 1'b0;
`endif

  assign inst_valid_o = buf_valid | byp;
  assign inst_o       = byp ? mem_rdata_i : fifo_data[rd_ptr];
  assign inst_addr_o  = byp ? tag_head    : fifo_addr[rd_ptr];
  assign pop          = buf_valid & inst_ready_i & ~jump_en_i;
  assign push         = keep & ~(byp & inst_ready_i);

  // Control FSM: idle for one cycle after reset, then fetch forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else begin
      case (state)
        S_IDLE:  state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  // PC, in-flight count and number of responses to discard after a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= out_next;
      if (jump_en_i)    pc <= target;
      else if (fire)    pc <= pc + 32'd4;
      if (jump_en_i)               drop <= out_next;
      else if (rv && drop != '0)   drop <= drop - OW'(1);
    end
  end

  // Tag queue: PC of every granted request, retired in order by rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr <= '0;
      tag_rd <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
    end else begin
      if (fire) begin
        tag_mem[tag_wr] <= pc;
        tag_wr          <= tag_inc(tag_wr);
      end
      if (rv) tag_rd <= tag_inc(tag_rd);
    end
  end

  // Instruction buffer; a redirect empties it and suppresses this cycle's pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= NOP;
        fifo_addr[i] <= '0;
      end
    end else if (jump_en_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata_i;
        fifo_addr[wr_ptr] <= tag_head;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  // Memory must never return data that was not requested.
  a_no_spurious_rvalid: assert property (@(posedge clk) disable iff (rst)
    mem_rvalid_i |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized scoreboard bench for ifetch_unit. The expected instruction stream
// is sequential program order from the reset PC or the latest redirect target;
// a monitor compares every decode handshake against it.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_OUTSTANDING = 2;
`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] inst_o, inst_addr_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;

  int checks = 0, errors = 0;
  int cyc = 0, fires = 0, accepts = 0;
  int first_fire_cyc = -1, first_valid_cyc = -1;
  int gnt_mode = 0;   // 0 always, 1 random, 2 never
  int rv_mode = 0;    // 0 asap, 1 random, 2 hold
  bit stale_rv = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH),
                .MAX_OUTSTANDING(MAX_OUTSTANDING)) dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: word k holds "addi x(10+k), x0, k+1".
  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] k;
    k = a >> 2;
    return ((k + 32'd1) << 20) | (((k + 32'd10) & 32'h1f) << 7) | 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Program order restarts at 'start'.
  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 512; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input bit stale);
    tick();
    stale_rv = stale;
    rst = 1'b1;
    jump_en_i = 1'b0;
    #1;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, RESET_PC);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'h0000_0013);
    chk("rst_inst_addr", inst_addr_o, 32'd0);
    refill(RESET_PC);
    first_fire_cyc = -1;
    first_valid_cyc = -1;
    fires = 0;
    repeat (3) begin
      tick();
      chk("rst_hold_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_hold_req", 32'(mem_req_o), 32'd0);
    end
    stale_rv = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Memory model: in-order responses, at least one cycle after grant.
  initial begin
    bit g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_rvalid_i && pend.size() > 0) void'(pend.pop_front());
        if (mem_req_o && mem_gnt_i) begin
          pend.push_back(mem_addr_o);
          fires++;
          if (first_fire_cyc < 0) first_fire_cyc = cyc;
          chk("outstanding_limit", 32'(pend.size() <= MAX_OUTSTANDING), 32'd1);
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        pend.delete();
        mem_gnt_i = 1'b0;
        mem_rvalid_i = stale_rv;
        mem_rdata_i = 32'hDEAD_BEEF;
      end else begin
        case (gnt_mode)
          0:       g = 1'b1;
          1:       g = 1'($urandom % 2);
          default: g = 1'b0;
        endcase
        mem_gnt_i = g;
        mem_rvalid_i = (pend.size() > 0) &&
                       (rv_mode == 0 || (rv_mode == 1 && ($urandom % 2) == 0));
        mem_rdata_i = mem_rvalid_i ? memf(pend[0]) : 32'hBAD0_0000;
      end
    end
  end

  // Monitor: checks handshakes against program order and bus stability rules.
  initial begin
    logic [31:0] pa, pi, pia, e;
    bit pstall, phold;
    pstall = 1'b0;
    phold = 1'b0;
    pa = '0; pi = '0; pia = '0;
    forever begin
      @(negedge clk);
      if (rst || jump_en_i) begin
        pstall = 1'b0;
        phold = 1'b0;
        continue;
      end
      if (pstall) begin
        chk("addr_stable_until_gnt", mem_addr_o, pa);
        chk("req_held_until_gnt", 32'(mem_req_o), 32'd1);
      end
      if (phold) begin
        chk("hold_valid", 32'(inst_valid_o), 32'd1);
        chk("hold_inst", inst_o, pi);
        chk("hold_inst_addr", inst_addr_o, pia);
      end
      if (mem_req_o) chk("addr_align", 32'(mem_addr_o[1:0]), 32'd0);
      if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (inst_valid_o && inst_ready_i) begin
        accepts++;
        if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("inst_addr", inst_addr_o, e);
          chk("inst_data", inst_o, memf(e));
        end
      end
      pstall = mem_req_o && !mem_gnt_i;
      pa = mem_addr_o;
      phold = inst_valid_o && !inst_ready_i;
      pi = inst_o;
      pia = inst_addr_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ja;
    int acc0;

    // Basic streaming: latency and program order.
    gnt_mode = 0; rv_mode = 0; inst_ready_i = 1'b1;
    apply_reset(1'b0);
    repeat (14) tick();
    chk("first_valid_latency", 32'(first_valid_cyc - first_fire_cyc), 32'(LAT));
    chk("stream_progress", 32'(accepts >= 4), 32'd1);

    // Decode stalled: buffer fills, requests stop, head held.
    inst_ready_i = 1'b0;
    apply_reset(1'b0);
    repeat (10) tick();
    @(negedge clk);
    chk("full_req_low", 32'(mem_req_o), 32'd0);
    chk("full_valid", 32'(inst_valid_o), 32'd1);
    chk("full_head_inst", inst_o, 32'h0010_0513);
    chk("full_head_addr", inst_addr_o, 32'd0);
    chk("full_fire_count", 32'(fires), 32'(FIFO_DEPTH));
    tick();
    inst_ready_i = 1'b1;
    repeat (10) tick();

    // Redirect with two requests in flight: both responses discarded.
    rv_mode = 2;
    apply_reset(1'b0);
    for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
    chk("two_outstanding", 32'(pend.size()), 32'd2);
    jump_en_i = 1'b1; jump_addr_i = 32'h100; refill(32'h100);
    tick();
    jump_en_i = 1'b0;
    @(negedge clk);
    chk("jump_target_addr", mem_addr_o, 32'h100);
    rv_mode = 0;
    acc0 = accepts;
    repeat (15) tick();
    chk("jump_progress", 32'(accepts > acc0), 32'd1);

    // Misaligned redirect target is word aligned.
    jump_en_i = 1'b1; jump_addr_i = 32'h203; refill(32'h200);
    tick();
    jump_en_i = 1'b0;
    @(negedge clk);
    chk("jump_align_addr", mem_addr_o, 32'h200);
    repeat (10) tick();

    // Grant withheld: address and request hold, PC advances only on grant.
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req_o && mem_gnt_i) break;
    end
    chk("first_fetch_addr", mem_addr_o, RESET_PC);
    gnt_mode = 2;
    repeat (3) begin
      @(negedge clk);
      chk("stall_req", 32'(mem_req_o), 32'd1);
      chk("stall_addr", mem_addr_o, 32'h4);
    end
    gnt_mode = 0;
    repeat (10) tick();

    // Reset mid-stream with responses pending and stale rvalids during reset.
    rv_mode = 2;
    for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
    chk("pre_reset_outstanding", 32'(pend.size()), 32'd2);
    apply_reset(1'b1);
    rv_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req_o) break;
    end
    chk("restart_addr", mem_addr_o, RESET_PC);
    repeat (10) tick();

    // Randomized traffic with redirects, including near the address wrap.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 200 == 0) begin
        gnt_mode = int'($urandom % 2);
        rv_mode = int'($urandom % 2);
      end
      inst_ready_i = ($urandom % 4) != 0;
      if (($urandom % 40) == 0) begin
        ja = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
        jump_en_i = 1'b1;
        jump_addr_i = ja;
        refill({ja[31:2], 2'b00});
      end else begin
        jump_en_i = 1'b0;
      end
    end
    tick();
    jump_en_i = 1'b0;
    inst_ready_i = 1'b1;
    gnt_mode = 0;
    rv_mode = 0;
    repeat (30) tick();
    chk("random_progress", 32'(accepts > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
